// File: rtl/vga_pkg.sv
// Shared constants for the VGA framebuffer arbiter: screen geometry,
// framebuffer geometry and the commit FSM state encodings.
package vga_pkg;

  // 640x480 screen timing, active region only
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  // Framebuffer is the screen downscaled by 4 in both directions
  localparam int unsigned SCALE_SH = 2;
  localparam int unsigned FB_W     = H_ACTIVE >> SCALE_SH;  // 160
  localparam int unsigned FB_H     = V_ACTIVE >> SCALE_SH;  // 120
  localparam int unsigned FB_AW    = 15;                    // 19200 words fit
  localparam int unsigned DW       = 12;                    // 4:4:4 RGB

  // Writer request buffering
  localparam int unsigned FIFO_DEPTH = 4;

  // Commit FSM states
  localparam logic [1:0] RUN  = 2'd0;  // writer may push, no swap pending
  localparam logic [1:0] PEND = 2'd1;  // swap requested, draining and waiting for vblank
  localparam logic [1:0] SWAP = 2'd2;  // flip front/back on the next edge

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding writer requests ({offset, pixel}) until a
// free memory slot drains them. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH      = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] store [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = store[rd_ptr];

  // Storage array: no reset needed, contents are only read behind count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; reset discards everything held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port, double-buffered framebuffer RAM between VGA
// scan-out and a pixel writer.
//
// Handshake: a writer request transfers on a rising edge where
// wr_valid && wr_ready; wr_valid may be held while wr_ready is low, and the
// transfer is fixed in the FIFO once accepted.
//
// A 4-phase counter divides the 100 MHz clock into 25 MHz pixel slots. The
// phase-0 slot of an active pixel is reserved for the display read; every
// other cycle may drain one buffered write into the back buffer. A commit
// requests a front/back swap that is deferred until the FIFO is drained and
// the beam is in vertical blanking, so scan-out never tears.
module vga_fb_arbiter #(
  parameter int DW         = 12,
  parameter int FB_W       = 160,
  parameter int FB_AW      = 15,
  parameter int SCALE_SH   = 2,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  output logic             pix_stb,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             de,
  output logic [DW-1:0]    pix_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             commit,
  output logic             commit_busy,
  output logic             front_sel,
  output logic             mem_en,
  output logic             mem_we,
  output logic [FB_AW:0]   mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  import vga_pkg::*;

  localparam int EW = FB_AW + DW;

  logic [1:0]       ph;
  logic [1:0]       state;
  logic             rd_pend;
  logic             disp_slot;
  logic [FB_AW-1:0] disp_off;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    fifo_dout;
  logic [FB_AW-1:0] fifo_off;
  logic [DW-1:0]    fifo_pix;
  logic             in_vblank;

  // Phase counter and pixel strobe; pix_stb is high while ph == 3 so the
  // timing generator steps x/y on the edge into ph == 0
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      ph      <= 2'd0;
      pix_stb <= 1'b0;
    end else begin
      ph      <= ph + 2'd1;
      pix_stb <= (ph == 2'd2);
    end
  end

  // Display slot: phase 0 of an active pixel always belongs to scan-out
  assign disp_slot = (ph == 2'd0) && de;

  // Screen coordinate to framebuffer offset; the product is deliberately
  // truncated to the offset width
  assign disp_off = FB_AW'((32'(y >> SCALE_SH) * 32'(FB_W)) + 32'(x >> SCALE_SH));

  // Pixel capture: the read issued at ph 0 returns during ph 1 and is
  // latched on that edge; blanked pixels show black
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      rd_pend  <= 1'b0;
      pix_data <= '0;
    end else begin
      if (ph == 2'd0) begin
        rd_pend <= de;
      end
      if (ph == 2'd1) begin
        pix_data <= rd_pend ? mem_rdata : '0;
      end
    end
  end

  // Writer side: accept only while running, out of reset and not full
  assign wr_ready = CPU_RESETN && !fifo_full && (state == RUN);
  assign push     = wr_valid && wr_ready;
  assign pop      = CPU_RESETN && !fifo_empty && !disp_slot;
  assign fifo_off = fifo_dout[EW-1:DW];
  assign fifo_pix = fifo_dout[DW-1:0];

  sync_fifo #(
    .WIDTH      (EW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK100MHZ),
    .rst_n     (CPU_RESETN),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // RAM port mux: display read has fixed priority, otherwise drain a write
  // into the buffer that is not being displayed
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (CPU_RESETN) begin
      if (disp_slot) begin
        mem_en   = 1'b1;
        mem_addr = {front_sel, disp_off};
      end else if (!fifo_empty) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {~front_sel, fifo_off};
        mem_wdata = fifo_pix;
      end
    end
  end

  assign in_vblank = (y >= 10'(V_ACTIVE));

  // Commit FSM: request, drain and wait for vblank, then flip buffers
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state       <= RUN;
      front_sel   <= 1'b0;
      commit_busy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (commit) begin
            state       <= PEND;
            commit_busy <= 1'b1;
          end
        end
        PEND: begin
          if (fifo_empty && !pop && in_vblank) begin
            state <= SWAP;
          end
        end
        SWAP: begin
          front_sel   <= ~front_sel;
          commit_busy <= 1'b0;
          state       <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: a behavioural RAM, a pixel-slot
// driver, and a reference model built from queues and plain arithmetic.
module tb_vga_fb_arbiter;

  import vga_pkg::*;

  localparam int W = FB_AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             CPU_RESETN;
  logic             pix_stb;
  logic [9:0]       x;
  logic [9:0]       y;
  logic             de;
  logic [DW-1:0]    pix_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [FB_AW-1:0] wr_addr;
  logic [DW-1:0]    wr_data;
  logic             commit;
  logic             commit_busy;
  logic             front_sel;
  logic             mem_en;
  logic             mem_we;
  logic [FB_AW:0]   mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;

  vga_fb_arbiter dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (CPU_RESETN),
    .pix_stb     (pix_stb),
    .x           (x),
    .y           (y),
    .de          (de),
    .pix_data    (pix_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_busy (commit_busy),
    .front_sel   (front_sel),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Behavioural single-port RAM, one-cycle read latency
  logic [DW-1:0] ram [0:(1<<(FB_AW+1))-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0]  exp_q[$];   // accepted writes not yet seen on the RAM bus
  int            m_ph;       // clocks since release, modulo 4
  bit            m_rst_edge; // previous edge sampled reset
  bit            m_busy;     // commit accepted, swap not yet done
  int            m_cd;       // cycles until the flip becomes visible
  bit            m_front;
  logic [DW-1:0] exp_pix;
  bit            hs;
  logic [9:0]    nx, ny;
  logic          nde;

  function automatic int fb_off(input logic [9:0] px, input logic [9:0] py);
    return ((int'(py) / 4) * FB_W + int'(px) / 4) % (1 << FB_AW);
  endfunction

  // One clock: present inputs, check outputs mid-cycle, advance the model
  task automatic cycle();
    logic [FB_AW:0] a;
    logic [W-1:0]   e;
    int             sz;
    if (m_ph == 0) begin
      x = nx; y = ny; de = nde;
    end
    #1;
    hs = 1'b0;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        m_front = !m_front;
        m_busy  = 1'b0;
      end
    end
    if (!CPU_RESETN) begin
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      if (m_rst_edge) begin
        chk("rst_pix_stb", 32'(pix_stb), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_front_sel", 32'(front_sel), 32'd0);
        chk("rst_commit_busy", 32'(commit_busy), 32'd0);
      end
      m_ph = 0; m_busy = 0; m_cd = 0; m_front = 0; exp_pix = '0;
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      chk("pix_stb", 32'(pix_stb), 32'(m_ph == 3));
      chk("commit_busy", 32'(commit_busy), 32'(m_busy));
      chk("front_sel", 32'(front_sel), 32'(m_front));
      chk("wr_ready", 32'(wr_ready), 32'(!m_busy && sz < FIFO_DEPTH));
      if (m_ph == 3) chk("pix_data", 32'(pix_data), 32'(exp_pix));
      if (m_ph == 0 && de) begin
        a = {m_front, FB_AW'(fb_off(x, y))};
        chk("rd_en", 32'(mem_en), 32'd1);
        chk("rd_we", 32'(mem_we), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'(a));
        exp_pix = ram[a];
      end else begin
        if (m_ph == 0) exp_pix = '0;
        if (sz > 0) begin
          e = exp_q.pop_front();
          chk("wr_en", 32'(mem_en), 32'd1);
          chk("wr_we", 32'(mem_we), 32'd1);
          chk("wr_addr", 32'(mem_addr), 32'({!m_front, e[W-1:DW]}));
          chk("wr_data", 32'(mem_wdata), 32'(e[DW-1:0]));
        end else begin
          chk("idle_en", 32'(mem_en), 32'd0);
        end
      end
      // swap becomes visible two cycles after drain + vblank is seen
      if (m_busy && m_cd == 0 && sz == 0 && y >= V_ACTIVE) m_cd = 2;
      hs = wr_valid && wr_ready;
      if (hs) exp_q.push_back({wr_addr, wr_data});
      if (commit && !m_busy) m_busy = 1'b1;
      m_ph = (m_ph + 1) % 4;
    end
    m_rst_edge = !CPU_RESETN;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_write(input logic [FB_AW-1:0] a, input logic [DW-1:0] d);
    int n;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!hs && n < 100);
    if (!hs) chk("wr_accept_timeout", 32'd0, 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < (1 << (FB_AW + 1)); i++) ram[i] = DW'($urandom);
    CPU_RESETN = 1'b0;
    x = '0; y = '0; de = 1'b0; nx = '0; ny = '0; nde = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    m_ph = 0; m_busy = 0; m_cd = 0; m_front = 0; exp_pix = '0;
    @(negedge clk);
    m_rst_edge = 1'b1;

    // reset held for three cycles
    repeat (3) cycle();
    CPU_RESETN = 1'b1;

    // display read of a known pixel, then a blanked pixel
    ram[165] = 12'hABC;
    nx = 10'd20; ny = 10'd4; nde = 1'b1;
    repeat (8) cycle();
    nde = 1'b0;
    repeat (8) cycle();

    // four writes during active video
    nx = 10'd100; ny = 10'd50; nde = 1'b1;
    for (int i = 1; i <= 4; i++) send_write(FB_AW'(i), DW'(i * 12'h111));
    repeat (8) cycle();
    for (int i = 1; i <= 4; i++) begin
      chk("buf1_content", 32'(ram[{1'b1, FB_AW'(i)}]), 32'(i * 12'h111));
    end

    // commit in active video waits for vblank
    ny = 10'd100;
    pulse_commit();
    repeat (40) cycle();
    ny = 10'd480; nde = 1'b0;
    repeat (12) cycle();
    chk("front_after_commit", 32'(front_sel), 32'd1);

    // commit together with a write, plus an ignored second commit
    ny = 10'd200; nde = 1'b1;
    repeat (4) cycle();
    wr_valid = 1'b1; wr_addr = FB_AW'(7); wr_data = 12'h5A5;
    pulse_commit();
    wr_valid = 1'b0;
    repeat (5) cycle();
    pulse_commit();
    repeat (20) cycle();
    ny = 10'd480; nde = 1'b0;
    repeat (12) cycle();
    chk("front_single_toggle", 32'(front_sel), 32'd0);
    chk("buf0_offset7", 32'(ram[{1'b0, FB_AW'(7)}]), 32'h5A5);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      nx = 10'($urandom_range(0, 799));
      ny = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(480, 524))
                                       : 10'($urandom_range(0, 479));
      nde = (nx < 10'd640) && (ny < 10'd480);
      if (!wr_valid && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b1;
        wr_addr  = FB_AW'($urandom_range(0, 19199));
        wr_data  = DW'($urandom);
      end
      commit = ($urandom_range(0, 39) == 0);
      cycle();
      commit = 1'b0;
      if (hs) wr_valid = 1'b0;
    end
    wr_valid = 1'b0;

    // settle, then reset while a swap is pending with writes queued
    ny = 10'd480; nde = 1'b0;
    repeat (16) cycle();
    ny = 10'd100; nde = 1'b1;
    repeat (4) cycle();
    for (int i = 0; i < 12; i++) begin
      wr_valid = 1'b1;
      wr_addr  = FB_AW'($urandom_range(0, 19199));
      wr_data  = DW'($urandom);
      commit   = (i == 11);
      cycle();
    end
    wr_valid = 1'b0; commit = 1'b0;
    cycle();
    CPU_RESETN = 1'b0;
    repeat (3) cycle();
    CPU_RESETN = 1'b1;
    repeat (24) cycle();
    ny = 10'd480; nde = 1'b0;
    repeat (12) cycle();
    chk("front_after_reset", 32'(front_sel), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
